// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the ctrl_unit slice.
//   - datapath / register-index widths
//   - FSM state enum and opcode enum
//   - ALU operation codes and the opcode -> ALU code mapping
package ctrl_pkg;

    localparam int DATA_W = 8;
    localparam int RIDX_W = 2;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_MEM   = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    typedef enum logic [3:0] {
        OP_NOT  = 4'b0000,
        OP_AND  = 4'b0001,
        OP_OR   = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_ADD  = 4'b0100,
        OP_SUB  = 4'b0101,
        OP_SLL  = 4'b0110,
        OP_SRL  = 4'b0111,
        OP_LD   = 4'b1000,
        OP_ST   = 4'b1001,
        OP_BRZR = 4'b1010,
        OP_JI   = 4'b1011,
        OP_INC  = 4'b1100,
        OP_LDI  = 4'b1101,
        OP_SL4  = 4'b1110,
        OP_HLT  = 4'b1111
    } opcode_t;

    localparam logic [3:0] ALU_NOT  = 4'b0000;
    localparam logic [3:0] ALU_AND  = 4'b0001;
    localparam logic [3:0] ALU_OR   = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_ADD  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_INC  = 4'b1100;
    localparam logic [3:0] ALU_SL4  = 4'b1110;
    localparam logic [3:0] ALU_NONE = 4'b0000;

    // True for instructions whose result comes from the external ALU.
    function automatic logic uses_alu(input opcode_t op);
        case (op)
            OP_NOT, OP_AND, OP_OR, OP_XOR,
            OP_ADD, OP_SUB, OP_SLL, OP_SRL,
            OP_INC, OP_SL4: uses_alu = 1'b1;
            default:        uses_alu = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] alu_code(input opcode_t op);
        case (op)
            OP_NOT:  alu_code = ALU_NOT;
            OP_AND:  alu_code = ALU_AND;
            OP_OR:   alu_code = ALU_OR;
            OP_XOR:  alu_code = ALU_XOR;
            OP_ADD:  alu_code = ALU_ADD;
            OP_SUB:  alu_code = ALU_SUB;
            OP_SLL:  alu_code = ALU_SLL;
            OP_SRL:  alu_code = ALU_SRL;
            OP_INC:  alu_code = ALU_INC;
            OP_SL4:  alu_code = ALU_SL4;
            default: alu_code = ALU_NONE;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_unit_reg_bank.sv
// reg_bank: 4 x 8-bit general register file.
//   clk        - clock, write on rising edge
//   rst        - asynchronous active-high reset, clears all registers
//   i_we       - write enable
//   i_waddr    - write register index
//   i_wdata    - write data
//   i_raddr_a  - read port A index (asynchronous read)
//   i_raddr_b  - read port B index (asynchronous read)
//   o_rdata_a  - read port A data
//   o_rdata_b  - read port B data
module reg_bank
    import ctrl_pkg::*;
#(
    parameter int NREGS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [RIDX_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [RIDX_W-1:0] i_raddr_a,
    input  logic [RIDX_W-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b
);

    logic [DATA_W-1:0] r_regs [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_regs[i_raddr_a];
    assign o_rdata_b = r_regs[i_raddr_b];

endmodule

// File: rtl/ctrl_unit.sv
// ctrl_unit: multi-cycle controller for an 8-bit accumulator-style CPU.
// Instruction: [7:4] opcode, [3:2] ra, [1:0] rb, imm4 = [3:0].
// FSM FETCH -> EXEC -> (MEM) -> FETCH; HALT only with CTRL_HALT_EN defined.
// Build option: CTRL_HALT_EN - opcode 1111 enters HALT (else NOP, halted=0).
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   mem_addr          - pc in FETCH, R[rb] in MEM
//   mem_rd, mem_wr    - read / write request, held until mem_ready
//   mem_wdata         - store data, R[ra]
//   mem_rdata         - read data, valid with mem_ready
//   mem_ready         - completes the pending access at the sampling edge
//   alu_op            - ALU operation (0000 for non-ALU instructions)
//   alu_ra, alu_rb    - ALU operands R[ra], R[rb]
//   alu_s, alu_zero   - ALU result and zero flag
//   halted            - high while in HALT
module ctrl_unit
    import ctrl_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter int         NREGS    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [7:0]  mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready,
    output logic [3:0]  alu_op,
    output logic [7:0]  alu_ra,
    output logic [7:0]  alu_rb,
    input  logic [7:0]  alu_s,
    input  logic        alu_zero,
    output logic        halted
);

    state_t            r_state, w_next;
    logic [DATA_W-1:0] r_pc, w_pc_next;
    logic [DATA_W-1:0] r_ir;
    logic              r_z, w_z_next;
    logic              w_ir_load;
    logic              w_we;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_ra_val, w_rb_val;
    opcode_t           w_op;
    logic [RIDX_W-1:0] w_ra, w_rb;

    assign w_op = opcode_t'(r_ir[7:4]);
    assign w_ra = r_ir[3:2];
    assign w_rb = r_ir[1:0];

    reg_bank #(.NREGS(NREGS)) u_reg_bank (
        .clk       (clk),
        .rst       (rst),
        .i_we      (w_we),
        .i_waddr   (w_ra),
        .i_wdata   (w_wdata),
        .i_raddr_a (w_ra),
        .i_raddr_b (w_rb),
        .o_rdata_a (w_ra_val),
        .o_rdata_b (w_rb_val)
    );

    assign alu_ra    = w_ra_val;
    assign alu_rb    = w_rb_val;
    assign mem_wdata = w_ra_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FETCH;
            r_pc    <= RESET_PC;
            r_ir    <= '0;
            r_z     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_pc    <= w_pc_next;
            r_z     <= w_z_next;
            if (w_ir_load) begin
                r_ir <= mem_rdata;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        w_pc_next = r_pc;
        w_z_next  = r_z;
        w_ir_load = 1'b0;
        w_we      = 1'b0;
        w_wdata   = alu_s;
        alu_op    = ALU_NONE;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = r_pc;

        case (r_state)
            ST_FETCH: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    w_ir_load = 1'b1;
                    w_pc_next = r_pc + 8'd1;
                    w_next    = ST_EXEC;
                end
            end

            ST_EXEC: begin
                w_next = ST_FETCH;
                if (uses_alu(w_op)) begin
                    alu_op   = alu_code(w_op);
                    w_we     = 1'b1;
                    w_wdata  = alu_s;
                    w_z_next = alu_zero;
                end else begin
                    case (w_op)
                        OP_LDI: begin
                            w_we    = 1'b1;
                            w_wdata = {{(DATA_W-RIDX_W){1'b0}}, w_rb};
                        end
                        OP_LD, OP_ST: w_next = ST_MEM;
                        OP_BRZR: begin
                            if (r_z) begin
                                w_pc_next = w_rb_val;
                            end
                        end
                        // pc already points past the JI, so the offset is relative to pc+1
                        OP_JI: w_pc_next = r_pc + {{4{r_ir[3]}}, r_ir[3:0]};
                        OP_HLT: begin
`ifdef CTRL_HALT_EN
                            w_next = ST_HALT;
`else
                            w_next = ST_FETCH;
`endif
                        end
                        default: ;
                    endcase
                end
            end

            ST_MEM: begin
                mem_addr = w_rb_val;
                if (w_op == OP_LD) begin
                    mem_rd = 1'b1;
                end else begin
                    mem_wr = 1'b1;
                end
                if (mem_ready) begin
                    if (w_op == OP_LD) begin
                        w_we    = 1'b1;
                        w_wdata = mem_rdata;
                    end
                    w_next = ST_FETCH;
                end
            end

            ST_HALT: ;

            default: w_next = ST_FETCH;
        endcase
    end

`ifdef CTRL_HALT_EN
    assign halted = (r_state == ST_HALT);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_unit.sv
// tb_ctrl_unit: scoreboard bench for ctrl_unit.
// An instruction-level reference model runs each program ahead of time and
// queues the memory accesses it should produce; a monitor pops and compares
// every completed access. A memory responder serves requests with a grant
// budget so the DUT stalls once the expected trace is exhausted.
module tb_ctrl_unit;

    localparam logic [7:0] RESET_PC = 8'h00;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] mem_addr, mem_wdata, alu_ra, alu_rb, alu_s;
    logic [7:0] mem_rdata;
    logic       mem_rd, mem_wr, alu_zero, halted;
    logic       mem_ready;
    logic [3:0] alu_op;

    always #5 clk = ~clk;

    typedef struct packed {
        logic       wr;
        logic       fetch;
        logic [7:0] addr;
        logic [7:0] data;
        logic [3:0] aop;
    } acc_t;

    acc_t       exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] mem [256];
    int         grants = 0;
    int         fixed_dly = 0;
    bit         rand_dly = 1'b0;
    int         wr_cycles = 0;
    int         wr_hs = 0;

    // Behavioural ALU attached to the DUT.
    function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'b0000: return ~a;
            4'b0001: return a & b;
            4'b0010: return a | b;
            4'b0011: return a ^ b;
            4'b0100: return a + b;
            4'b0101: return a - b;
            4'b0110: return a << b[2:0];
            4'b0111: return a >> b[2:0];
            4'b1100: return b + 8'd1;
            4'b1110: return b << 4;
            default: return 8'h00;
        endcase
    endfunction

    assign alu_s    = alu_fn(alu_op, alu_ra, alu_rb);
    assign alu_zero = (alu_s == 8'h00);

    ctrl_unit #(.RESET_PC(RESET_PC), .NREGS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .alu_op    (alu_op),
        .alu_ra    (alu_ra),
        .alu_rb    (alu_rb),
        .alu_s     (alu_s),
        .alu_zero  (alu_zero),
        .halted    (halted)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    // Instruction-level model: queues the expected access trace of n instructions.
    task automatic ref_run(input int n);
        logic [7:0] m [256];
        logic [7:0] r [4];
        logic [7:0] pc, ir, res;
        logic [1:0] ra, rb;
        bit         z, stop;
        acc_t       e;
        m    = mem;
        for (int i = 0; i < 4; i++) r[i] = 8'h00;
        pc   = RESET_PC;
        z    = 1'b0;
        stop = 1'b0;
        for (int k = 0; k < n && !stop; k++) begin
            ir      = m[pc];
            ra      = ir[3:2];
            rb      = ir[1:0];
            e       = '0;
            e.fetch = 1'b1;
            e.addr  = pc;
            e.aop   = (!ir[7] || ir[7:4] == 4'd12 || ir[7:4] == 4'd14) ? ir[7:4] : 4'd0;
            exp_q.push_back(e);
            pc = pc + 8'd1;
            if (!ir[7]) begin
                res   = alu_fn(ir[7:4], r[ra], r[rb]);
                r[ra] = res;
                z     = (res == 8'h00);
            end else begin
                case (ir[7:4])
                    4'd12: begin res = r[rb] + 8'd1; r[ra] = res; z = (res == 8'h00); end
                    4'd14: begin res = r[rb] << 4;   r[ra] = res; z = (res == 8'h00); end
                    4'd13: r[ra] = {6'b0, rb};
                    4'd8: begin
                        e = '0; e.addr = r[rb];
                        exp_q.push_back(e);
                        r[ra] = m[r[rb]];
                    end
                    4'd9: begin
                        e = '0; e.wr = 1'b1; e.addr = r[rb]; e.data = r[ra];
                        exp_q.push_back(e);
                        m[r[rb]] = r[ra];
                    end
                    4'd10: if (z) pc = r[rb];
                    4'd11: pc = pc + {{4{ir[3]}}, ir[3:0]};
                    default: begin
`ifdef CTRL_HALT_EN
                        stop = 1'b1;
`endif
                    end
                endcase
            end
        end
        grants = exp_q.size();
    endtask

    task automatic responder();
        int cnt = 0;
        int dly = 0;
        forever begin
            @(posedge clk); #2;
            if (mem_ready) begin
                mem_ready = 1'b0;
                cnt = 0;
            end
            if (rst) begin
                cnt = 0;
            end else if ((mem_rd || mem_wr) && grants > 0) begin
                if (cnt == 0) dly = rand_dly ? int'($urandom_range(0, 3)) : fixed_dly;
                if (cnt >= dly) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem[mem_addr];
                    if (mem_wr) mem[mem_addr] = mem_wdata;
                    grants--;
                end else begin
                    cnt++;
                end
            end
        end
    endtask

    task automatic monitor();
        acc_t       e;
        bit         chk_aop = 1'b0;
        logic [3:0] want_aop = 4'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk_aop = 1'b0;
            end else begin
                if (chk_aop) begin
                    check("alu_op_in_exec", 32'(alu_op), 32'(want_aop));
                    chk_aop = 1'b0;
                end
                check("rd_wr_exclusive", 32'(mem_rd & mem_wr), 32'd0);
                if (mem_wr) wr_cycles++;
                if (mem_ready && (mem_rd || mem_wr)) begin
                    if (mem_wr) wr_hs++;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_access: got wr=%0b addr=0x%0h, expected no access", mem_wr, mem_addr);
                    end else begin
                        e = exp_q.pop_front();
                        check("mem_access", 32'({mem_wr, mem_addr, (e.wr ? mem_wdata : 8'h00)}),
                              32'({e.wr, e.addr, e.data}));
                        if (e.fetch) begin
                            chk_aop  = 1'b1;
                            want_aop = e.aop;
                        end
                    end
                end
            end
        end
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_mem_rd"},   32'(mem_rd),   32'd1);
        check({tag, "_mem_wr"},   32'(mem_wr),   32'd0);
        check({tag, "_halted"},   32'(halted),   32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'(RESET_PC));
    endtask

    // Leaves rst asserted, at posedge+1.
    task automatic begin_prog();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic go(input int n);
        ref_run(n);
        rst = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int t = 0;
        while (exp_q.size() != 0 && t < budget) begin
            @(posedge clk); #1;
            t++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain_timeout: %0d accesses still pending after %0d cycles, expected 0", exp_q.size(), t);
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int   w0, h0;
        acc_t e;
        mem_ready = 1'b0;
        mem_rdata = 8'h00;
        fork
            responder();
            monitor();
        join_none

        // LDI R1,2; LDI R2,3; ADD R1,R2; ST R1,[R2]; BRZR R0 (Z=0, falls through)
        begin_prog();
        mem[0] = 8'hD6; mem[1] = 8'hDB; mem[2] = 8'h46; mem[3] = 8'h96; mem[4] = 8'hA0;
        reset_checks("during_reset");
        go(6);
        #3;
        reset_checks("after_release");
        repeat (5) @(posedge clk);
        #4;
        check("add_alu_op", 32'(alu_op), 32'h4);
        @(posedge clk); #4;
        check("three_instr_6_cycles", 32'({mem_rd, mem_addr}), 32'({1'b1, 8'h03}));
        wait_drain(200);

        // LDI R0,1; SUB R0,R0; BRZR R3 -> back to 0x00
        begin_prog();
        mem[0] = 8'hD1; mem[1] = 8'h50; mem[2] = 8'hAF;
        go(4);
        wait_drain(200);

        // LDI R1,3; SL4 R2,R1; ST R2,[R1] with 3 wait cycles
        begin_prog();
        mem[0] = 8'hD7; mem[1] = 8'hE9; mem[2] = 8'h99;
        fixed_dly = 3;
        w0 = wr_cycles;
        h0 = wr_hs;
        go(3);
        wait_drain(300);
        check("st_wr_held_cycles", 32'(wr_cycles - w0), 32'd4);
        check("st_single_write", 32'(wr_hs - h0), 32'd1);
        fixed_dly = 0;

        // JI -2 at 0x01 -> 0x00
        begin_prog();
        mem[0] = 8'hDC; mem[1] = 8'hBE;
        go(4);
        wait_drain(200);

        // JI -2 at 0x00 -> 0xFF; JI +1 at 0xFF -> 0x01
        begin_prog();
        mem[0] = 8'hBE; mem[8'hFF] = 8'hB1;
        go(3);
        wait_drain(200);

        // Reset during a stalled LD, then read back the target register
        begin_prog();
        mem[0] = 8'h88;
        e = '0; e.fetch = 1'b1; e.addr = 8'h00;
        exp_q.push_back(e);
        grants = 1;
        rst = 1'b0;
        wait_drain(100);
        check("ld_waiting", 32'({mem_rd, mem_wr, mem_addr}), 32'({1'b1, 1'b0, 8'h00}));
        rst = 1'b1;
        #2;
        reset_checks("abort_reset");
        begin_prog();
        mem[0] = 8'h9A;
        go(2);
        wait_drain(200);

        // Opcode 1111
        begin_prog();
        mem[0] = 8'hF0; mem[1] = 8'hD0;
        go(2);
        wait_drain(200);
`ifdef CTRL_HALT_EN
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_no_fetch", 32'({mem_rd, mem_wr}), 32'd0);
`else
        check("nop_halted_low", 32'(halted), 32'd0);
`endif

        // Random programs with random wait states
        rand_dly = 1'b1;
        for (int p = 0; p < 25; p++) begin
            begin_prog();
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
            go(40);
            wait_drain(2000);
        end

        begin_prog();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ctrl_unit.md
CTRL_UNIT -- requirements
Module: ctrl_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'h00, meaning the program counter value loaded on reset.
REQ-002 SHALL have parameter NREGS, default 4, meaning the general register count; fixed at 4, matching the 2-bit fields.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 mem_addr  output  8  memory address (pc in FETCH, R[rb] in MEM).
REQ-006 mem_rd  output  1  read request; held until mem_ready.
REQ-007 mem_wr  output  1  write request; held until mem_ready.
REQ-008 mem_wdata  output  8  store data, equal to R[ra].
REQ-009 mem_rdata  input  8  read data, valid when mem_ready=1.
REQ-010 mem_ready  input  1  completes the pending access at the sampling edge.
REQ-011 alu_op  output  4  ALU operation code.
REQ-012 alu_ra, alu_rb  output  8 each  ALU operands, equal to R[ra] and R[rb].
REQ-013 alu_s  input  8  ALU result.
REQ-014 alu_zero  input  1  ALU zero flag.
REQ-015 halted  output  1  high while in HALT.

Function
REQ-016 Instruction format SHALL be [7:4] opcode, [3:2] ra, [1:0] rb; imm4 = [3:0].
REQ-017 FSM states SHALL be FETCH, EXEC, MEM and HALT; mem_rd, mem_wr and halted SHALL be Moore outputs of the state.
REQ-018 FETCH: mem_rd=1, mem_addr=pc; on mem_ready the FSM SHALL latch the instruction, set pc<=pc+1 (wrap 8'hFF->8'h00), and go to EXEC; otherwise it stays in FETCH.
REQ-019 Opcodes 0000-0111 (NOT, AND, OR, XOR, ADD, SUB, SLL, SRL) SHALL drive alu_op=opcode and write R[ra]<=alu_s and Z<=alu_zero at the end of EXEC, then go to FETCH.
REQ-020 Opcode 1100 (INC) SHALL drive alu_op=1100 and write R[ra]<=R[rb]+1 via the ALU; opcode 1110 (SL4) SHALL drive alu_op=1110 and write R[ra]<=R[rb]<<4; both SHALL update Z.
REQ-021 Opcode 1101 (LDI) SHALL write R[ra]<={6'b0,rb}, leave Z unchanged, and not use the ALU result.
REQ-022 Opcode 1000 (LD) and opcode 1001 (ST) SHALL go from EXEC to MEM; MEM holds mem_rd or mem_wr with mem_addr=R[rb]; on mem_ready, LD writes R[ra]<=mem_rdata; then the FSM goes to FETCH.
REQ-023 Opcode 1010 (BRZR) SHALL set pc<=R[rb] if Z=1, else leave pc unchanged.
REQ-024 Opcode 1011 (JI) SHALL set pc<=pc+sign_extend(imm4), modulo 256, computed internally.
REQ-025 During non-ALU instructions alu_op SHALL be 4'b0000, and Z SHALL be unchanged.
REQ-026 Latency with a zero-wait memory SHALL be 2 cycles per ALU, branch or LDI instruction and 3 cycles for LD and ST.
REQ-027 mem_rd and mem_wr SHALL never be high together.

Reset
REQ-028 On rst: pc<=RESET_PC, R0-R3<=0, Z<=0, state<=FETCH, instruction register<=0.
REQ-029 During and immediately after reset: mem_rd=1 (FETCH), mem_wr=0, halted=0, mem_addr=RESET_PC.
REQ-030 Reset asserted during a MEM access SHALL abort the access with no register write.

Configuration
REQ-031 Macro CTRL_HALT_EN defined: opcode 1111 SHALL enter HALT, where halted=1, no memory requests are made, and the FSM exits only on reset.
REQ-032 Macro CTRL_HALT_EN undefined: opcode 1111 SHALL be a NOP returning to FETCH, and halted SHALL be tied to 0.

Structure
REQ-033 Package ctrl_pkg SHALL hold the opcode constants, the FSM state enum, and the ALU op codes (0000-0111, 1100, 1110).
REQ-034 The register bank SHALL be a sub-module named reg_bank: 4x8, two async read ports, one sync write port, async reset.

Verification
REQ-035 Program LDI R1,2; LDI R2,3; ADD R1,R2 -> R1=5, Z=0, alu_op=0100 seen in EXEC; 6 cycles total with zero-wait memory.
REQ-036 Program LDI R0,1; SUB R0,R0; BRZR R3 (R3=0) -> Z=1 and pc=0x00 after BRZR.
REQ-037 Program LDI R1,3; SL4 R2,R1; ST R2,[R1] with mem_ready delayed 3 cycles -> single write of 0x30 to address 0x03, with mem_wr held 4 cycles.
REQ-038 JI imm4=4'hE at pc=0x01 -> next fetch address 0x00; JI at pc=0xFF with imm4=1 -> wrap to 0x01.
REQ-039 rst pulsed mid-LD with mem_ready low -> target register remains 0, and fetch restarts at RESET_PC.
REQ-040 Opcode 1111 -> halted=1 with no further mem_rd when CTRL_HALT_EN is defined, or next fetch at pc+1 when it is undefined.
